hopctrlwd_seq: RTL and testbench

HOPCTRLWD_SEQ -- requirements
Module: hopctrlwd_seq

---
 rtl/hopctrlwd_seq.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_hopctrlwd_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hopctrlwd_seq.sv
// Sequential hop-selection control-word generator with a bit-serial restoring divider.
// Define HOPCTRLWD_AFH_EN to build the afh_n remainder path (Fprime, err_p).
module hopctrlwd_seq #(
  parameter int unsigned CLKW = 28,
  parameter int unsigned NW   = 7
) (
  input  logic            clk_6M,
  input  logic            rst,
  input  logic            start_p,
  input  logic [3:0]      mode,
  input  logic [CLKW-1:0] CLK,
  input  logic [CLKW-1:0] CLKN,
  input  logic [CLKW-1:0] CLKE,
  input  logic [27:0]     BD_ADDR,
  input  logic            Atrain,
  input  logic            afh_mode,
  input  logic            pstxid,
  input  logic            psrxfhs,
  input  logic [4:0]      k_nudge,
  input  logic [4:0]      interlace_offset,
  input  logic [4:0]      counter_isFHS,
  input  logic [5:0]      counter_clkN1,
  input  logic [5:0]      counter_clkE1,
  input  logic            mpr_Y,
  input  logic [NW-1:0]   afh_n,
  output logic            busy,
  output logic            valid_p,
  output logic            err_p,
  output logic            ovr_p,
  output logic [4:0]      X,
  output logic            Y1,
  output logic [5:0]      Y2,
  output logic [4:0]      A,
  output logic [3:0]      B,
  output logic [4:0]      C,
  output logic [8:0]      D,
  output logic [6:0]      E,
  output logic [6:0]      F,
  output logic [NW-1:0]   Fprime
);

  localparam int unsigned DW   = CLKW - 3;
  localparam int unsigned CntW = $clog2(DW);

  localparam logic [3:0] ModePs    = 4'd0;
  localparam logic [3:0] ModeGips  = 4'd1;
  localparam logic [3:0] ModeIs    = 4'd2;
  localparam logic [3:0] ModeGiis  = 4'd3;
  localparam logic [3:0] ModePage  = 4'd4;
  localparam logic [3:0] ModeInq   = 4'd5;
  localparam logic [3:0] ModeMpr   = 4'd6;
  localparam logic [3:0] ModeSpr   = 4'd7;
  localparam logic [3:0] ModeIr    = 4'd8;
  localparam logic [3:0] ModeConns = 4'd9;

  typedef enum logic [1:0] {StIdle, StDiv, StOut} state_e;

  state_e state_q, state_d;
  logic   accept;

  // Snapshot of every input taken at acceptance
  logic [3:0]      mode_q;
  logic [CLKW-1:0] clk_q, clkn_q, clke_q;
  logic [27:0]     bd_q;
  logic            atrain_q, afh_mode_q, pstxid_q, psrxfhs_q, mpr_y_q;
  logic [4:0]      knudge_q, ioff_q, cis_q;
  logic [5:0]      cn1_q, ce1_q;

  logic [CntW-1:0] cnt_q;
  logic [DW-1:0]   dvd_q;
  logic [6:0]      r79_q;
  logic [7:0]      r79_sh, r79_nx;

  logic            valid_q, err_q, ovr_q;
  logic [4:0]      x_q, a_q, c_q;
  logic            y1_q;
  logic [3:0]      b_q;
  logic [8:0]      d_q;
  logic [6:0]      e_q, f_q;
  logic [NW-1:0]   fp_q;

  logic [4:0]      x_n, a_n, c_n;
  logic            y1_n;
  logic [8:0]      d_n;
  logic [6:0]      f_n;
  logic [NW-1:0]   fp_n;
  logic            err_n;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_p) begin
          accept  = 1'b1;
          state_d = StDiv;
        end
      end
      StDiv:   if (cnt_q == CntW'(DW - 1)) state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_6M) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Restoring step: shift in next dividend bit, subtract divisor when it fits
  assign r79_sh = {r79_q, dvd_q[DW-1]};
  assign r79_nx = (r79_sh >= 8'd79) ? (r79_sh - 8'd79) : r79_sh;

`ifdef HOPCTRLWD_AFH_EN
  logic [NW-1:0] afhn_q, raf_q;
  logic [NW:0]   raf_sh, raf_nx;

  assign raf_sh = {raf_q, dvd_q[DW-1]};
  assign raf_nx = (raf_sh >= {1'b0, afhn_q}) ? (raf_sh - {1'b0, afhn_q}) : raf_sh;
  assign err_n  = (afhn_q == '0);
  assign fp_n   = (mode_q == ModeConns && !err_n) ? raf_q : '0;

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      afhn_q <= '0;
      raf_q  <= '0;
    end else if (accept) begin
      afhn_q <= afh_n;
      raf_q  <= '0;
    end else if (state_q == StDiv) begin
      raf_q  <= raf_nx[NW-1:0];
    end
  end

  logic unused_afh;
  assign unused_afh = raf_nx[NW];
`else
  assign err_n = 1'b0;
  assign fp_n  = '0;

  logic unused_afh;
  assign unused_afh = ^afh_n;
`endif

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      mode_q     <= '0;
      clk_q      <= '0;
      clkn_q     <= '0;
      clke_q     <= '0;
      bd_q       <= '0;
      atrain_q   <= 1'b0;
      afh_mode_q <= 1'b0;
      pstxid_q   <= 1'b0;
      psrxfhs_q  <= 1'b0;
      mpr_y_q    <= 1'b0;
      knudge_q   <= '0;
      ioff_q     <= '0;
      cis_q      <= '0;
      cn1_q      <= '0;
      ce1_q      <= '0;
      cnt_q      <= '0;
      dvd_q      <= '0;
      r79_q      <= '0;
    end else if (accept) begin
      mode_q     <= mode;
      clk_q      <= CLK;
      clkn_q     <= CLKN;
      clke_q     <= CLKE;
      bd_q       <= BD_ADDR;
      atrain_q   <= Atrain;
      afh_mode_q <= afh_mode;
      pstxid_q   <= pstxid;
      psrxfhs_q  <= psrxfhs;
      mpr_y_q    <= mpr_Y;
      knudge_q   <= k_nudge;
      ioff_q     <= interlace_offset;
      cis_q      <= counter_isFHS;
      cn1_q      <= counter_clkN1;
      ce1_q      <= counter_clkE1;
      cnt_q      <= '0;
      dvd_q      <= {CLK[CLKW-1:7], 4'b0000};
      r79_q      <= '0;
    end else if (state_q == StDiv) begin
      cnt_q      <= cnt_q + CntW'(1);
      dvd_q      <= {dvd_q[DW-2:0], 1'b0};
      r79_q      <= r79_nx[6:0];
    end
  end

  // Zero-extended clocks so narrow CLKW builds still index bits up to 25
  logic [31:0] clk32, clkn32, clke32;
  assign clk32  = 32'(clk_q);
  assign clkn32 = 32'(clkn_q);
  assign clke32 = 32'(clke_q);

  function automatic logic [4:0] page_x(input logic [4:0] hi, input logic [3:0] lo,
                                        input logic atr, input logic [4:0] kn);
    logic [3:0] ph;
    ph = lo - hi[3:0];
    return hi + (atr ? 5'd24 : 5'd8) + kn + {1'b0, ph};
  endfunction

  logic [4:0] xir, pg_e, pg_n;
  assign xir  = clkn32[16:12] + cis_q;
  assign pg_e = page_x(clke32[16:12], {clke32[4:2], clke32[0]}, atrain_q, knudge_q);
  assign pg_n = page_x(clkn32[16:12], {clkn32[4:2], clkn32[0]}, atrain_q, knudge_q);

  always_comb begin
    x_n  = '0;
    y1_n = 1'b0;
    a_n  = '0;
    c_n  = '0;
    d_n  = '0;
    f_n  = '0;
    if (mode_q <= ModeConns) begin
      a_n = bd_q[27:23];
      c_n = {bd_q[8], bd_q[6], bd_q[4], bd_q[2], bd_q[0]};
      d_n = bd_q[18:10];
    end
    case (mode_q)
      ModePs:   x_n = clkn32[16:12];
      ModeGips: x_n = clkn32[16:12] + ioff_q;
      ModeIs:   x_n = xir;
      ModeGiis: x_n = xir + ioff_q;
      ModePage: begin
        x_n  = pg_e;
        y1_n = clke32[1];
      end
      ModeInq: begin
        x_n  = pg_n;
        y1_n = clkn32[1];
      end
      ModeMpr: begin
        x_n  = pg_e + ce1_q[5:1];
        y1_n = mpr_y_q;
      end
      ModeSpr: begin
        x_n  = clkn32[16:12] + cn1_q[5:1];
        y1_n = pstxid_q | (~psrxfhs_q & cn1_q[0]);
      end
      ModeIr: begin
        x_n  = xir;
        y1_n = 1'b1;
      end
      ModeConns: begin
        x_n  = clk32[6:2];
        y1_n = clk32[1] & ~afh_mode_q;
        a_n  = a_n ^ clk32[25:21];
        c_n  = c_n ^ clk32[20:16];
        d_n  = d_n ^ clk32[15:7];
        f_n  = r79_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      x_q     <= '0;
      y1_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      f_q     <= '0;
      fp_q    <= '0;
    end else begin
      valid_q <= (state_q == StOut);
      err_q   <= (state_q == StOut) && err_n;
      ovr_q   <= start_p && (state_q != StIdle);
      if (state_q == StOut) begin
        x_q  <= x_n;
        y1_q <= y1_n;
        a_q  <= a_n;
        b_q  <= bd_q[22:19];
        c_q  <= c_n;
        d_q  <= d_n;
        e_q  <= {bd_q[13], bd_q[11], bd_q[9], bd_q[7], bd_q[5], bd_q[3], bd_q[1]};
        f_q  <= f_n;
        fp_q <= fp_n;
      end
    end
  end

  assign busy    = (state_q != StIdle);
  assign valid_p = valid_q;
  assign err_p   = err_q;
  assign ovr_p   = ovr_q;
  assign X       = x_q;
  assign Y1      = y1_q;
  assign Y2      = {y1_q, 5'b00000};
  assign A       = a_q;
  assign B       = b_q;
  assign C       = c_q;
  assign D       = d_q;
  assign E       = e_q;
  assign F       = f_q;
  assign Fprime  = fp_q;

  logic unused_snap;
  assign unused_snap = ^{clk32, clkn32, clke32, ce1_q[0], r79_nx[7]};

endmodule

// File: tb/tb_hopctrlwd_seq.sv
// Randomized bench for hopctrlwd_seq against an arithmetic reference model.
module tb_hopctrlwd_seq;

  localparam int unsigned CLKW = 28;
  localparam int unsigned NW   = 7;
  localparam int          LAT  = CLKW - 2;

  logic            clk_6M = 1'b0;
  logic            rst, start_p;
  logic [3:0]      mode;
  logic [CLKW-1:0] CLK, CLKN, CLKE;
  logic [27:0]     BD_ADDR;
  logic            Atrain, afh_mode, pstxid, psrxfhs, mpr_Y;
  logic [4:0]      k_nudge, interlace_offset, counter_isFHS;
  logic [5:0]      counter_clkN1, counter_clkE1;
  logic [NW-1:0]   afh_n;
  logic            busy, valid_p, err_p, ovr_p, Y1;
  logic [4:0]      X, A, C;
  logic [5:0]      Y2;
  logic [3:0]      B;
  logic [8:0]      D;
  logic [6:0]      E, F;
  logic [NW-1:0]   Fprime;

  always #5 clk_6M = ~clk_6M;

  hopctrlwd_seq #(.CLKW(CLKW), .NW(NW)) dut (
    .clk_6M(clk_6M), .rst(rst), .start_p(start_p), .mode(mode),
    .CLK(CLK), .CLKN(CLKN), .CLKE(CLKE), .BD_ADDR(BD_ADDR),
    .Atrain(Atrain), .afh_mode(afh_mode), .pstxid(pstxid), .psrxfhs(psrxfhs),
    .k_nudge(k_nudge), .interlace_offset(interlace_offset), .counter_isFHS(counter_isFHS),
    .counter_clkN1(counter_clkN1), .counter_clkE1(counter_clkE1), .mpr_Y(mpr_Y),
    .afh_n(afh_n), .busy(busy), .valid_p(valid_p), .err_p(err_p), .ovr_p(ovr_p),
    .X(X), .Y1(Y1), .Y2(Y2), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .Fprime(Fprime)
  );

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  int unsigned s_mode, s_clk, s_clkn, s_clke, s_bd, s_atrain, s_afhmode, s_pstxid;
  int unsigned s_psrxfhs, s_knudge, s_io, s_cis, s_cn1, s_ce1, s_mpry, s_afhn;
  int unsigned e_x, e_y1, e_a, e_b, e_c, e_d, e_e, e_f, e_fp, e_err;
  int unsigned prev_x = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned fld(input int unsigned v, input int lo, input int w);
    return (v >> lo) & ((32'd1 << w) - 1);
  endfunction

  function automatic int unsigned page_x(input int unsigned c);
    int hi, lo4, d;
    hi  = int'(fld(c, 12, 5));
    lo4 = int'(fld(c, 2, 3) * 2 + fld(c, 0, 1));
    d   = ((lo4 - hi) % 16 + 16) % 16;
    return int'(hi + (s_atrain != 0 ? 24 : 8) + int'(s_knudge) + d) % 32;
  endfunction

  task automatic model_expect();
    int unsigned xir, dividend;
    xir = (fld(s_clkn, 12, 5) + s_cis) % 32;
    e_x = 0; e_y1 = 0; e_a = 0; e_c = 0; e_d = 0; e_f = 0; e_fp = 0; e_err = 0;
    e_b = fld(s_bd, 19, 4);
    e_e = 0;
    for (int i = 0; i < 7; i++) e_e |= fld(s_bd, 2 * i + 1, 1) << i;
    if (s_mode <= 9) begin
      e_a = fld(s_bd, 23, 5);
      for (int i = 0; i < 5; i++) e_c |= fld(s_bd, 2 * i, 1) << i;
      e_d = fld(s_bd, 10, 9);
    end
    case (s_mode)
      0: e_x = fld(s_clkn, 12, 5);
      1: e_x = (fld(s_clkn, 12, 5) + s_io) % 32;
      2: e_x = xir;
      3: e_x = (xir + s_io) % 32;
      4: begin e_x = page_x(s_clke); e_y1 = fld(s_clke, 1, 1); end
      5: begin e_x = page_x(s_clkn); e_y1 = fld(s_clkn, 1, 1); end
      6: begin e_x = (page_x(s_clke) + fld(s_ce1, 1, 5)) % 32; e_y1 = s_mpry; end
      7: begin
        e_x  = (fld(s_clkn, 12, 5) + fld(s_cn1, 1, 5)) % 32;
        e_y1 = s_pstxid | ((1 - s_psrxfhs) & fld(s_cn1, 0, 1));
      end
      8: begin e_x = xir; e_y1 = 1; end
      9: begin
        dividend = (s_clk >> 7) * 16;
        e_x  = fld(s_clk, 2, 5);
        e_y1 = fld(s_clk, 1, 1) & (1 - s_afhmode);
        e_a ^= fld(s_clk, 21, 5);
        e_c ^= fld(s_clk, 16, 5);
        e_d ^= fld(s_clk, 7, 9);
        e_f  = dividend % 79;
`ifdef HOPCTRLWD_AFH_EN
        if (s_afhn != 0) e_fp = dividend % s_afhn;
`endif
      end
      default: ;
    endcase
`ifdef HOPCTRLWD_AFH_EN
    e_err = (s_afhn == 0) ? 1 : 0;
`endif
  endtask

  task automatic randomize_stim();
    s_mode    = $urandom_range(0, 15);
    s_clk     = $urandom & 32'h0FFF_FFFF;
    s_clkn    = $urandom & 32'h0FFF_FFFF;
    s_clke    = $urandom & 32'h0FFF_FFFF;
    s_bd      = $urandom & 32'h0FFF_FFFF;
    s_atrain  = $urandom_range(0, 1);
    s_afhmode = $urandom_range(0, 1);
    s_pstxid  = $urandom_range(0, 1);
    s_psrxfhs = $urandom_range(0, 1);
    s_mpry    = $urandom_range(0, 1);
    s_knudge  = $urandom_range(0, 31);
    s_io      = $urandom_range(0, 31);
    s_cis     = $urandom_range(0, 31);
    s_cn1     = $urandom_range(0, 63);
    s_ce1     = $urandom_range(0, 63);
    s_afhn    = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127);
  endtask

  task automatic drive_stim();
    mode = s_mode[3:0]; CLK = s_clk[CLKW-1:0]; CLKN = s_clkn[CLKW-1:0];
    CLKE = s_clke[CLKW-1:0]; BD_ADDR = s_bd[27:0]; Atrain = s_atrain[0];
    afh_mode = s_afhmode[0]; pstxid = s_pstxid[0]; psrxfhs = s_psrxfhs[0];
    mpr_Y = s_mpry[0]; k_nudge = s_knudge[4:0]; interlace_offset = s_io[4:0];
    counter_isFHS = s_cis[4:0]; counter_clkN1 = s_cn1[5:0]; counter_clkE1 = s_ce1[5:0];
    afh_n = s_afhn[NW-1:0];
  endtask

  // Scrambles the ports so a result depending on live inputs shows up
  task automatic drive_garbage();
    mode = 4'($urandom); CLK = CLKW'($urandom); CLKN = CLKW'($urandom);
    CLKE = CLKW'($urandom); BD_ADDR = 28'($urandom); Atrain = 1'($urandom);
    afh_mode = 1'($urandom); pstxid = 1'($urandom); psrxfhs = 1'($urandom);
    mpr_Y = 1'($urandom); k_nudge = 5'($urandom); interlace_offset = 5'($urandom);
    counter_isFHS = 5'($urandom); counter_clkN1 = 6'($urandom);
    counter_clkE1 = 6'($urandom); afh_n = NW'($urandom);
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".X"}, 64'(X), 64'(e_x));
    check_eq({tag, ".Y1"}, 64'(Y1), 64'(e_y1));
    check_eq({tag, ".Y2"}, 64'(Y2), 64'(e_y1 * 32));
    check_eq({tag, ".A"}, 64'(A), 64'(e_a));
    check_eq({tag, ".B"}, 64'(B), 64'(e_b));
    check_eq({tag, ".C"}, 64'(C), 64'(e_c));
    check_eq({tag, ".D"}, 64'(D), 64'(e_d));
    check_eq({tag, ".E"}, 64'(E), 64'(e_e));
    check_eq({tag, ".F"}, 64'(F), 64'(e_f));
    check_eq({tag, ".Fprime"}, 64'(Fprime), 64'(e_fp));
  endtask

  task automatic zero_expect();
    e_x = 0; e_y1 = 0; e_a = 0; e_b = 0; e_c = 0; e_d = 0; e_e = 0; e_f = 0; e_fp = 0;
  endtask

  // Called just after a rising edge; ovr_a/ovr_b are cycles of extra start_p (0 = none)
  task automatic run_txn(input string tag, input int ovr_a, input int ovr_b);
    int   n_valid, v_cyc;
    logic v_err, v_busy;
    model_expect();
    drive_stim();
    start_p = 1'b1;
    @(posedge clk_6M); #1;
    start_p = 1'b0;
    drive_garbage();
    n_valid = 0; v_cyc = 0; v_err = 1'b0; v_busy = 1'b1;
    for (int cyc = 1; cyc <= LAT + 4; cyc++) begin
      if (cyc == ovr_a || cyc == ovr_b) start_p = 1'b1;
      @(posedge clk_6M); #1;
      if (start_p) begin
        start_p = 1'b0;
        check_eq({tag, ".ovr_p"}, 64'(ovr_p), 64'd1);
        drive_garbage();
      end
      if (cyc == 1) begin
        check_eq({tag, ".busy"}, 64'(busy), 64'd1);
        check_eq({tag, ".hold_X"}, 64'(X), 64'(prev_x));
        if (ovr_a != 1) check_eq({tag, ".no_ovr"}, 64'(ovr_p), 64'd0);
      end
      if (valid_p) begin
        n_valid++; v_cyc = cyc; v_err = err_p; v_busy = busy;
      end
    end
    check_eq({tag, ".valid_count"}, 64'(n_valid), 64'd1);
    check_eq({tag, ".latency"}, 64'(v_cyc), 64'(LAT));
    check_eq({tag, ".busy_at_valid"}, 64'(v_busy), 64'd0);
    check_eq({tag, ".err_p"}, 64'(v_err), 64'(e_err));
    check_outputs(tag);
    prev_x = e_x;
  endtask

  initial begin
    int n_valid;
    rst = 1'b1; start_p = 1'b0;
    randomize_stim(); drive_stim();
    repeat (3) @(posedge clk_6M);
    #1;
    zero_expect();
    check_outputs("reset");
    check_eq("reset.busy", 64'(busy), 64'd0);
    check_eq("reset.valid", 64'(valid_p), 64'd0);
    check_eq("reset.ovr", 64'(ovr_p), 64'd0);
    check_eq("reset.err", 64'(err_p), 64'd0);
    rst = 1'b0;
    @(posedge clk_6M); #1;

    randomize_stim();
    s_mode = 9; s_clk = (32'd1 << 7) | (s_clk & 32'h7F); s_afhn = 37;
    run_txn("req034", 0, 0);
    check_eq("req034.F16", 64'(F), 64'd16);
`ifdef HOPCTRLWD_AFH_EN
    check_eq("req034.Fp16", 64'(Fprime), 64'd16);
`else
    check_eq("req034.Fp0", 64'(Fprime), 64'd0);
`endif

    randomize_stim();
    s_mode = 9; s_clk = (32'd5 << 7) | (s_clk & 32'h7F); s_afhn = 20; s_afhmode = 1;
    run_txn("req035", 0, 0);
    check_eq("req035.F1", 64'(F), 64'd1);
    check_eq("req035.Fp0", 64'(Fprime), 64'd0);
    check_eq("req035.Y1", 64'(Y1), 64'd0);

    randomize_stim();
    s_mode = 4; s_clke = 0; s_atrain = 1; s_knudge = 0;
    run_txn("req036", 0, 0);
    check_eq("req036.X24", 64'(X), 64'd24);
    check_eq("req036.Y1", 64'(Y1), 64'd0);
    check_eq("req036.A", 64'(A), 64'(s_bd >> 23));

    randomize_stim();
    s_mode = 9; s_afhn = 0;
    run_txn("req037", 10, LAT);

    // Reset in the middle of a division
    randomize_stim();
    s_mode = 9;
    drive_stim();
    start_p = 1'b1;
    @(posedge clk_6M); #1;
    start_p = 1'b0;
    repeat (11) @(posedge clk_6M);
    #1;
    rst = 1'b1;
    @(posedge clk_6M); #1;
    rst = 1'b0;
    zero_expect();
    check_outputs("rst_mid");
    check_eq("rst_mid.busy", 64'(busy), 64'd0);
    check_eq("rst_mid.valid", 64'(valid_p), 64'd0);
    n_valid = 0;
    repeat (LAT + 4) begin
      @(posedge clk_6M); #1;
      if (valid_p) n_valid++;
    end
    check_eq("rst_mid.no_valid", 64'(n_valid), 64'd0);
    prev_x = 0;

    // start_p coincident with rst is ignored
    rst = 1'b1; start_p = 1'b1;
    @(posedge clk_6M); #1;
    rst = 1'b0; start_p = 1'b0;
    check_eq("rst_start.busy", 64'(busy), 64'd0);
    @(posedge clk_6M); #1;
    check_eq("rst_start.busy2", 64'(busy), 64'd0);

    randomize_stim();
    run_txn("after_rst", 0, 0);

    for (int t = 0; t < 40; t++) begin
      randomize_stim();
      if (t % 4 == 0) s_mode = 9;
      run_txn($sformatf("rand%0d_m%0d", t, s_mode), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
